// File: rtl/bus_controller.sv
// 68000 bus front end: address decode into active-low chip selects, DTACK
// generation with per-region wait states, DRAM DTACK merge, autovector VPA for
// interrupt acknowledge, bus-error watchdog and a post-reset boot ROM overlay.
module bus_controller #(
  parameter int ROM_WAIT     = 2,
  parameter int IO_WAIT      = 4,
  parameter int BERR_TIMEOUT = 255,
  parameter int BOOT_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic        RW,
  input  logic [2:0]  FC,
  input  logic [22:0] ADDR_IN,
  input  logic        DTACK_DRAM,
  output logic        CS_DRAM,
  output logic        CS_ROM,
  output logic        CS_IO,
  output logic        DTACK,
  output logic        BERR,
  output logic        VPA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_BERR
  } state_t;

  typedef enum logic [2:0] {
    R_DRAM,
    R_ROM,
    R_IO,
    R_NONE,
    R_IACK
  } region_t;

  localparam logic [7:0] ROM_WAIT_C = 8'(ROM_WAIT);
  localparam logic [7:0] IO_WAIT_C  = 8'(IO_WAIT);
  localparam logic [7:0] WDT_LAST_C = 8'(BERR_TIMEOUT - 1);
  localparam logic [7:0] BOOT_C     = 8'(BOOT_CYCLES);

  state_t     state_q, state_d;
  region_t    region_q, region_d;
  region_t    region_dec;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] wdt_q, wdt_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic       vpa_q, vpa_d;
  logic       ack;

  // RW never changes the decode and the low address bits select nothing here.
  logic unused_inputs;
  assign unused_inputs = ^{RW, ADDR_IN[14:0]};

  // Region decode; ADDR_IN[22:k] equals byte address bits [23:k+1].
  always_comb begin
    region_dec = R_DRAM;
    if (FC == 3'b111)                   region_dec = R_IACK;
    else if (boot_cnt_q < BOOT_C)       region_dec = R_ROM;
    else if (ADDR_IN[22:18] == 5'b11110) region_dec = R_ROM;
    else if (ADDR_IN[22:15] == 8'hFF)    region_dec = R_IO;
    else if (ADDR_IN[22:18] == 5'b11111) region_dec = R_NONE;
    else                                region_dec = R_DRAM;
  end

  assign CS_DRAM = ~(~AS && (region_dec == R_DRAM));
  assign CS_ROM  = ~(~AS && (region_dec == R_ROM));
  assign CS_IO   = ~(~AS && (region_dec == R_IO));
  assign DTACK   = dtack_q & DTACK_DRAM;
  assign BERR    = berr_q;
  assign VPA     = vpa_q;

  // Next-state logic: cycle start, acknowledge/timeout arbitration, release.
  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    wait_cnt_d = wait_cnt_q;
    wdt_d      = wdt_q;
    boot_cnt_d = boot_cnt_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    vpa_d      = vpa_q;
    ack        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!AS) begin
          region_d   = region_dec;
          wait_cnt_d = 8'd0;
          wdt_d      = 8'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (AS) begin
          state_d = S_IDLE;
        end else begin
          unique case (region_q)
            R_ROM: begin
              if (wait_cnt_q == ROM_WAIT_C) begin
                dtack_d = 1'b0;
                ack     = 1'b1;
              end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
              end
            end
            R_IO: begin
              if (wait_cnt_q == IO_WAIT_C) begin
                dtack_d = 1'b0;
                ack     = 1'b1;
              end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
              end
            end
            R_DRAM: begin
              // The DRAM's own DTACK reaches the CPU through the output AND.
              if (!DTACK_DRAM) ack = 1'b1;
            end
            R_IACK: begin
              vpa_d = 1'b0;
              ack   = 1'b1;
            end
            default: ack = 1'b0;
          endcase
          // An acknowledge on the timeout edge takes priority over BERR.
          if (ack) begin
            state_d = S_ACK;
          end else if (wdt_q == WDT_LAST_C) begin
            berr_d  = 1'b0;
            state_d = S_BERR;
          end else begin
            wdt_d = wdt_q + 8'd1;
          end
        end
      end
      S_ACK, S_BERR: begin
        if (AS) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
          state_d = S_IDLE;
          if (state_q == S_ACK && boot_cnt_q < BOOT_C)
            boot_cnt_d = boot_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset that re-arms the overlay.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      region_q   <= R_DRAM;
      wait_cnt_q <= 8'd0;
      wdt_q      <= 8'd0;
      boot_cnt_q <= 8'd0;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      vpa_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      wait_cnt_q <= wait_cnt_d;
      wdt_q      <= wdt_d;
      boot_cnt_q <= boot_cnt_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      vpa_q      <= vpa_d;
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: transaction-level reference model compared every
// cycle, directed boot/ROM/DRAM/BERR/IACK/reset scenarios and random bus cycles.
module tb_bus_controller;

  localparam int ROM_WAIT     = 2;
  localparam int IO_WAIT      = 4;
  localparam int BERR_TIMEOUT = 255;
  localparam int BOOT_CYCLES  = 4;

  localparam int RG_DRAM = 0, RG_ROM = 1, RG_IO = 2, RG_NONE = 3, RG_IACK = 4;
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_ACKED = 2, M_BERRED = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        AS = 1'b1;
  logic        RW = 1'b1;
  logic [2:0]  FC = 3'b101;
  logic [22:0] ADDR_IN = '0;
  logic        DTACK_DRAM = 1'b1;
  logic        CS_DRAM, CS_ROM, CS_IO, DTACK, BERR, VPA;

  int checks = 0;
  int errors = 0;

  bus_controller #(
    .ROM_WAIT(ROM_WAIT), .IO_WAIT(IO_WAIT),
    .BERR_TIMEOUT(BERR_TIMEOUT), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .AS(AS), .RW(RW), .FC(FC), .ADDR_IN(ADDR_IN),
    .DTACK_DRAM(DTACK_DRAM), .CS_DRAM(CS_DRAM), .CS_ROM(CS_ROM), .CS_IO(CS_IO),
    .DTACK(DTACK), .BERR(BERR), .VPA(VPA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int region_of(input logic [22:0] a, input logic [2:0] fc, input int boot);
    int b;
    b = int'(a) * 2;
    if (fc == 3'b111)                        return RG_IACK;
    if (boot < BOOT_CYCLES)                  return RG_ROM;
    if (b >= 'hF00000 && b <= 'hF7FFFF)      return RG_ROM;
    if (b >= 'hFF0000)                       return RG_IO;
    if (b >= 'hF80000)                       return RG_NONE;
    return RG_DRAM;
  endfunction

  // Does the cycle get acknowledged on edge E<n>?
  function automatic bit acked_at(input int rg, input int n, input logic dd);
    case (rg)
      RG_ROM:  return n == ROM_WAIT + 1;
      RG_IO:   return n == IO_WAIT + 1;
      RG_DRAM: return !dd;
      RG_IACK: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  int   m_phase = M_IDLE, m_n = 0, m_reg = 0, m_boot = 0;
  logic m_dtack = 1'b1, m_berr = 1'b1, m_vpa = 1'b1;

  always @(posedge CLK) begin
    if (!RST) begin
      m_phase <= M_IDLE; m_n <= 0; m_reg <= 0; m_boot <= 0;
      m_dtack <= 1'b1; m_berr <= 1'b1; m_vpa <= 1'b1;
    end else begin
      case (m_phase)
        M_IDLE: if (!AS) begin
          m_reg   <= region_of(ADDR_IN, FC, m_boot);
          m_n     <= 0;
          m_phase <= M_ACTIVE;
        end
        M_ACTIVE: begin
          m_n <= m_n + 1;
          if (AS) m_phase <= M_IDLE;
          else if (acked_at(m_reg, m_n + 1, DTACK_DRAM)) begin
            m_phase <= M_ACKED;
            if (m_reg == RG_ROM || m_reg == RG_IO) m_dtack <= 1'b0;
            if (m_reg == RG_IACK) m_vpa <= 1'b0;
          end else if (m_n + 1 == BERR_TIMEOUT) begin
            m_berr  <= 1'b0;
            m_phase <= M_BERRED;
          end
        end
        default: if (AS) begin
          if (m_phase == M_ACKED && m_boot < BOOT_CYCLES) m_boot <= m_boot + 1;
          m_phase <= M_IDLE;
          m_dtack <= 1'b1; m_berr <= 1'b1; m_vpa <= 1'b1;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    int r;
    r = region_of(ADDR_IN, FC, m_boot);
    check("cs_dram", CS_DRAM, !(!AS && r == RG_DRAM));
    check("cs_rom",  CS_ROM,  !(!AS && r == RG_ROM));
    check("cs_io",   CS_IO,   !(!AS && r == RG_IO));
    check("dtack",   DTACK,   m_dtack & DTACK_DRAM);
    check("berr",    BERR,    m_berr);
    check("vpa",     VPA,     m_vpa);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_addr(input logic [23:0] baddr);
    ADDR_IN = baddr[23:1];
  endtask

  // One bus cycle; dram_lat = ticks after E0 before DTACK_DRAM drops,
  // abort_after >= 0 releases AS after that many ticks regardless.
  task automatic run_cycle(input logic [23:0] baddr, input logic [2:0] fc, input logic rw,
                           input int dram_lat, input int abort_after);
    bit done;
    done = 1'b0;
    set_addr(baddr); FC = fc; RW = rw; AS = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (abort_after >= 0 && k >= abort_after) begin done = 1'b1; break; end
      if (!DTACK_DRAM || !BERR || !VPA || !DTACK) begin done = 1'b1; break; end
      if (k == dram_lat) DTACK_DRAM = 1'b0;
    end
    check("cycle_end_within_bound", done, 1'b1);
    AS = 1'b1; DTACK_DRAM = 1'b1;
    tick();
  endtask

  initial begin
    logic [23:0] a;
    int kind;

    // Reset
    tick(); tick();
    check("rst_dtack", DTACK, 1'b1);
    check("rst_berr", BERR, 1'b1);
    check("rst_vpa", VPA, 1'b1);
    check("rst_cs_rom", CS_ROM, 1'b1);
    check("rst_cs_dram", CS_DRAM, 1'b1);
    RST = 1'b1;
    tick();

    // Boot overlay: four ROM fetches at low addresses, then DRAM
    for (int i = 0; i < 4; i++) begin
      a = 24'(i * 2);
      set_addr(a); FC = 3'b110; RW = 1'b1; AS = 1'b0;
      #1;
      check("boot_cs_rom", CS_ROM, 1'b0);
      check("boot_cs_dram", CS_DRAM, 1'b1);
      run_cycle(a, 3'b110, 1'b1, 1000, -1);
    end
    set_addr(24'h000000); AS = 1'b0;
    #1;
    check("postboot_cs_dram", CS_DRAM, 1'b0);
    check("postboot_cs_rom", CS_ROM, 1'b1);
    run_cycle(24'h000000, 3'b110, 1'b1, 2, -1);

    // ROM read with two wait states
    set_addr(24'hF00010); FC = 3'b101; RW = 1'b1; AS = 1'b0;
    #1; check("rom_cs", CS_ROM, 1'b0);
    tick(); tick(); check("rom_dtack_E1", DTACK, 1'b1);
    tick(); check("rom_dtack_E2", DTACK, 1'b1);
    tick(); check("rom_dtack_E3", DTACK, 1'b0);
    AS = 1'b1;
    #1; check("rom_dtack_hold", DTACK, 1'b0);
    tick(); check("rom_dtack_release", DTACK, 1'b1);

    // DRAM write, DTACK_DRAM 5 cycles after AS
    set_addr(24'h001000); RW = 1'b0; AS = 1'b0;
    #1; check("dram_cs", CS_DRAM, 1'b0);
    repeat (5) tick();
    check("dram_dtack_before", DTACK, 1'b1);
    DTACK_DRAM = 1'b0;
    #1; check("dram_dtack_follow", DTACK, 1'b0);
    tick(); check("dram_dtack_ack", DTACK, 1'b0);
    check("dram_berr", BERR, 1'b1);
    AS = 1'b1; DTACK_DRAM = 1'b1;
    #1; check("dram_dtack_follow_hi", DTACK, 1'b1);
    tick(); RW = 1'b1;

    // Unmapped access times out into BERR at E255
    set_addr(24'hF80000); AS = 1'b0;
    #1;
    check("none_cs_dram", CS_DRAM, 1'b1);
    check("none_cs_rom", CS_ROM, 1'b1);
    check("none_cs_io", CS_IO, 1'b1);
    tick();
    repeat (254) tick();
    check("none_berr_E254", BERR, 1'b1);
    tick(); check("none_berr_E255", BERR, 1'b0);
    AS = 1'b1;
    tick(); check("none_berr_release", BERR, 1'b1);

    // Interrupt acknowledge answered with VPA
    set_addr(24'h000100); FC = 3'b111; AS = 1'b0;
    #1;
    check("iack_cs_dram", CS_DRAM, 1'b1);
    check("iack_cs_rom", CS_ROM, 1'b1);
    check("iack_cs_io", CS_IO, 1'b1);
    tick(); check("iack_vpa_E0", VPA, 1'b1);
    tick(); check("iack_vpa_E1", VPA, 1'b0);
    check("iack_dtack", DTACK, 1'b1);
    AS = 1'b1;
    tick(); check("iack_vpa_release", VPA, 1'b1);
    FC = 3'b101;

    // Reset in the middle of an IO wait re-arms the overlay
    set_addr(24'hFF0000); AS = 1'b0;
    #1; check("io_cs", CS_IO, 1'b0);
    tick(); tick();
    RST = 1'b0;
    tick();
    check("midrst_dtack", DTACK, 1'b1);
    check("midrst_berr", BERR, 1'b1);
    check("midrst_vpa", VPA, 1'b1);
    check("midrst_cs_io", CS_IO, 1'b1);
    check("midrst_cs_rom", CS_ROM, 1'b0);
    AS = 1'b1; RST = 1'b1;
    tick();
    set_addr(24'h000000); AS = 1'b0;
    #1; check("rearm_cs_rom", CS_ROM, 1'b0);
    check("rearm_cs_dram", CS_DRAM, 1'b1);
    // aborted cycle does not consume a boot slot
    run_cycle(24'h000000, 3'b101, 1'b1, 1000, 1);
    for (int i = 0; i < 4; i++) run_cycle(24'h000100, 3'b101, 1'b1, 1000, -1);
    set_addr(24'h000100); AS = 1'b0;
    #1; check("abort_keeps_boot_dram", CS_DRAM, 1'b0);
    run_cycle(24'h000100, 3'b101, 1'b1, 0, -1);

    // Random bus cycles
    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 40) begin
        a = 24'($urandom_range(0, 32'hEFFFFF)) & 24'hFFFFFE;
        run_cycle(a, 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 8)), -1);
      end else if (kind < 60) begin
        a = 24'hF00000 + 24'($urandom_range(0, 32'h7FFFF));
        run_cycle(a, 3'($urandom_range(0, 6)), 1'b1, 1000, -1);
      end else if (kind < 78) begin
        a = 24'hFF0000 + 24'($urandom_range(0, 32'hFFFF));
        run_cycle(a, 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1000, -1);
      end else if (kind < 86) begin
        a = 24'($urandom_range(0, 32'hFFFFFF));
        run_cycle(a, 3'b111, 1'b1, 1000, -1);
      end else if (kind < 89) begin
        a = 24'hF80000 + 24'($urandom_range(0, 32'h6FFFF));
        run_cycle(a, 3'($urandom_range(0, 6)), 1'b1, 1000, -1);
      end else if (kind < 97) begin
        a = 24'($urandom_range(0, 32'hFFFFFF));
        run_cycle(a, 3'($urandom_range(0, 7)), 1'b1,
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      end else begin
        RST = 1'b0;
        tick();
        RST = 1'b1;
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
